// File: rtl/winner_led_pkg.sv
// Shared types and defaults for the winner LED logic and the score accumulators.
package winner_led_pkg;

    localparam int SCORE_W_DEF   = 4;
    localparam int WIN_SCORE_DEF = 3;

    typedef logic [SCORE_W_DEF-1:0] score_t;

    typedef enum logic [1:0] {
        PLAY   = 2'd0,
        P1_WON = 2'd1,
        P2_WON = 2'd2
    } state_t;

endpackage

// File: rtl/winner_led_compare.sv
// Combinational winner decision: a player wins when eligible and either the
// opponent is not eligible or the player is strictly ahead.
module winner_compare #(
    parameter int SCORE_W   = 4,
    parameter int WIN_SCORE = 3
) (
    input  logic [SCORE_W-1:0] i_p1_score,
    input  logic [SCORE_W-1:0] i_p2_score,
    output logic               o_p1_win,
    output logic               o_p2_win
);

    localparam logic [SCORE_W-1:0] L_WIN = SCORE_W'(WIN_SCORE);

    logic w_p1_elig;
    logic w_p2_elig;

    assign w_p1_elig = (i_p1_score >= L_WIN);
    assign w_p2_elig = (i_p2_score >= L_WIN);

    // Strict comparison on the lead term keeps the two wins mutually exclusive.
    assign o_p1_win = w_p1_elig && (!w_p2_elig || (i_p1_score > i_p2_score));
    assign o_p2_win = w_p2_elig && (!w_p1_elig || (i_p2_score > i_p1_score));

endmodule

// File: rtl/winner_led.sv
// Registered winner LEDs. Define WINNER_LATCH_EN to latch the first winner
// until reset; otherwise the LEDs track the scores with one cycle of latency.
module winner_led
    import winner_led_pkg::*;
#(
    parameter int SCORE_W   = SCORE_W_DEF,
    parameter int WIN_SCORE = WIN_SCORE_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [SCORE_W-1:0] P1TTLSCR,
    input  logic [SCORE_W-1:0] P2TTLSCR,
    output logic               WinnerLEDP1,
    output logic               WinnerLEDP2
);

    logic w_p1_win;
    logic w_p2_win;

    winner_compare #(
        .SCORE_W   (SCORE_W),
        .WIN_SCORE (WIN_SCORE)
    ) u_compare (
        .i_p1_score (P1TTLSCR),
        .i_p2_score (P2TTLSCR),
        .o_p1_win   (w_p1_win),
        .o_p2_win   (w_p2_win)
    );

`ifdef WINNER_LATCH_EN
    state_t r_state;
    state_t w_state_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= PLAY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Won states are absorbing; only reset leaves them.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            PLAY: begin
                if (w_p1_win) begin
                    w_state_nxt = P1_WON;
                end else if (w_p2_win) begin
                    w_state_nxt = P2_WON;
                end
            end
            P1_WON:  w_state_nxt = P1_WON;
            P2_WON:  w_state_nxt = P2_WON;
            default: w_state_nxt = PLAY;
        endcase
    end

    assign WinnerLEDP1 = (r_state == P1_WON);
    assign WinnerLEDP2 = (r_state == P2_WON);
`else
    logic r_led_p1;
    logic r_led_p2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_led_p1 <= 1'b0;
            r_led_p2 <= 1'b0;
        end else begin
            r_led_p1 <= w_p1_win;
            r_led_p2 <= w_p2_win;
        end
    end

    assign WinnerLEDP1 = r_led_p1;
    assign WinnerLEDP2 = r_led_p2;
`endif

endmodule

// File: tb/tb_winner_led.sv
// Self-checking bench for winner_led against a score-rule reference model.
module tb_winner_led;

    localparam int SCORE_W   = 4;
    localparam int WIN_SCORE = 3;
    localparam int MAX_SCORE = (1 << SCORE_W) - 1;
`ifdef WINNER_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [SCORE_W-1:0] P1TTLSCR = '0;
    logic [SCORE_W-1:0] P2TTLSCR = '0;
    logic               WinnerLEDP1;
    logic               WinnerLEDP2;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: 0 = nobody, 1 = player 1, 2 = player 2
    int m_shown   = 0;
    int m_latched = 0;
    bit exp1, exp2;

    winner_led #(.SCORE_W(SCORE_W), .WIN_SCORE(WIN_SCORE)) dut (
        .clk         (clk),
        .reset       (reset),
        .P1TTLSCR    (P1TTLSCR),
        .P2TTLSCR    (P2TTLSCR),
        .WinnerLEDP1 (WinnerLEDP1),
        .WinnerLEDP2 (WinnerLEDP2)
    );

    always #5 clk = ~clk;

    function automatic int who_wins(input int a, input int b);
        int best;
        if (a < WIN_SCORE && b < WIN_SCORE) return 0;
        if (a == b) return 0;
        // Highest eligible score wins; an ineligible player counts as minus one.
        best = (a >= WIN_SCORE) ? a : -1;
        if (b >= WIN_SCORE && b > best) return 2;
        return 1;
    endfunction

    task automatic drive_cycle(input int a, input int b, input bit rst);
        int w;
        P1TTLSCR = a[SCORE_W-1:0];
        P2TTLSCR = b[SCORE_W-1:0];
        reset    = rst;
        @(posedge clk);
        w = who_wins(a, b);
        if (rst) begin
            m_latched = 0;
            m_shown   = 0;
        end else if (LATCH) begin
            if (m_latched == 0) m_latched = w;
            m_shown = m_latched;
        end else begin
            m_shown = w;
        end
        exp1 = (m_shown == 1);
        exp2 = (m_shown == 2);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive_cycle(3, 0, 1'b1);
            n_checks++;
            if (WinnerLEDP1 !== 1'b0 || WinnerLEDP2 !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold cyc%0d: got %b%b required 00", i, WinnerLEDP1, WinnerLEDP2);
            end
        end
        drive_cycle(3, 0, 1'b0);
        n_checks++;
        if (WinnerLEDP1 !== 1'b1 || WinnerLEDP2 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got %b%b required 10", WinnerLEDP1, WinnerLEDP2);
        end
    endtask

    task automatic test_tracking();
        int a_tab [3] = '{3, 0, 0};
        int b_tab [3] = '{0, 0, 3};
        drive_cycle(0, 0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive_cycle(a_tab[i], b_tab[i], 1'b0);
            n_checks++;
            if (WinnerLEDP1 !== exp1 || WinnerLEDP2 !== exp2) begin
                n_fail++;
                $display("FAIL tracking step%0d: got %b%b required %b%b", i, WinnerLEDP1, WinnerLEDP2, exp1, exp2);
            end
        end
    endtask

    task automatic test_compare();
        int a_tab [3] = '{3, 5, 4};
        int b_tab [3] = '{3, 4, 7};
        bit e1_tab [3] = '{1'b0, 1'b1, 1'b0};
        bit e2_tab [3] = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            drive_cycle(0, 0, 1'b1);
            drive_cycle(a_tab[i], b_tab[i], 1'b0);
            n_checks++;
            if (WinnerLEDP1 !== e1_tab[i] || WinnerLEDP2 !== e2_tab[i]) begin
                n_fail++;
                $display("FAIL compare %0d/%0d: got %b%b required %b%b", a_tab[i], b_tab[i],
                         WinnerLEDP1, WinnerLEDP2, e1_tab[i], e2_tab[i]);
            end
        end
    endtask

    task automatic test_boundaries();
        int a_tab [4] = '{2, MAX_SCORE, 0, WIN_SCORE};
        int b_tab [4] = '{2, MAX_SCORE, 0, WIN_SCORE - 1};
        bit e1_tab [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            drive_cycle(0, 0, 1'b1);
            drive_cycle(a_tab[i], b_tab[i], 1'b0);
            n_checks++;
            if (WinnerLEDP1 !== e1_tab[i] || WinnerLEDP2 !== 1'b0) begin
                n_fail++;
                $display("FAIL boundary %0d/%0d: got %b%b required %b0", a_tab[i], b_tab[i],
                         WinnerLEDP1, WinnerLEDP2, e1_tab[i]);
            end
        end
    endtask

    task automatic test_latch();
        drive_cycle(0, 0, 1'b1);
        drive_cycle(3, 0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive_cycle(0, 3, 1'b0);
            n_checks++;
            if (WinnerLEDP1 !== exp1 || WinnerLEDP2 !== exp2) begin
                n_fail++;
                $display("FAIL latch_hold cyc%0d: got %b%b required %b%b", i, WinnerLEDP1, WinnerLEDP2, exp1, exp2);
            end
        end
        drive_cycle(0, 3, 1'b1);
        drive_cycle(0, 3, 1'b0);
        n_checks++;
        if (WinnerLEDP1 !== 1'b0 || WinnerLEDP2 !== 1'b1) begin
            n_fail++;
            $display("FAIL latch_after_reset: got %b%b required 01", WinnerLEDP1, WinnerLEDP2);
        end
    endtask

    task automatic test_random();
        int a, b;
        bit rst;
        drive_cycle(0, 0, 1'b1);
        for (int i = 0; i < 1000; i++) begin
            // Mix full-range scores with values clustered around the threshold.
            if ($urandom_range(0, 1) == 0) begin
                a = $urandom_range(0, MAX_SCORE);
                b = $urandom_range(0, MAX_SCORE);
            end else begin
                a = $urandom_range(WIN_SCORE - 1, WIN_SCORE + 2);
                b = $urandom_range(WIN_SCORE - 1, WIN_SCORE + 2);
            end
            rst = ($urandom_range(0, 31) == 0);
            drive_cycle(a, b, rst);
            n_checks++;
            if (WinnerLEDP1 === 1'b1 && WinnerLEDP2 === 1'b1) begin
                n_fail++;
                $display("FAIL random_exclusive cyc%0d: got 11 required not both set", i);
            end
            n_checks++;
            if (WinnerLEDP1 !== exp1 || WinnerLEDP2 !== exp2) begin
                n_fail++;
                $display("FAIL random_model cyc%0d %0d/%0d: got %b%b required %b%b", i, a, b,
                         WinnerLEDP1, WinnerLEDP2, exp1, exp2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_tracking();
        test_compare();
        test_boundaries();
        test_latch();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
